add_share_arbiter: RTL and testbench

- Round-robin arbiter that time-shares one 16-bit saturating fixed-point adder between NUM_REQ requesters, e.g. FFT butterfly and magnitude/peak-sum stages.
- Latches the winner's operands, sequences the adder's enable/done handshake, and returns the saturated sum with a one-cycle ack.
- Sits between the requesting stages and the single adder instance; the adder connects through the add_* ports.

---
 rtl/add_share_arbiter_if.sv | 31 +++
 rtl/add_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_add_share_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_share_arbiter_if.sv
// Signal bundle between the requesting stages, the shared adder and add_share_arbiter.
// The slave modport is the arbiter's view; master is the requester/adder side.
interface add_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       ack;
    logic [WIDTH-1:0]         result;
    logic [IDW-1:0]           result_id;
    logic                     timeout_err;
    logic                     add_enable;
    logic [WIDTH-1:0]         add_a;
    logic [WIDTH-1:0]         add_b;
    logic [WIDTH-1:0]         add_sum;
    logic                     add_done;

    modport slave (
        input  req, req_a, req_b, add_sum, add_done,
        output ack, result, result_id, timeout_err, add_enable, add_a, add_b
    );

    modport master (
        output req, req_a, req_b, add_sum, add_done,
        input  ack, result, result_id, timeout_err, add_enable, add_a, add_b
    );
endinterface

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter time-sharing one saturating adder between NUM_REQ requesters.
// Optional macro ADD_ARB_TIMEOUT_EN adds a TIMEOUT-clock watchdog on the adder's done flag.
module add_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    add_share_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_param_check
        $error("add_share_arbiter: NUM_REQ must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t             state_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [IDW-1:0]     grant_id_q;
    logic [IDW-1:0]     result_id_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   add_a_q;
    logic [WIDTH-1:0]   add_b_q;
    logic               add_en_q;

    logic [IDW-1:0]     grant_id_d;
    logic [IDW-1:0]     rr_ptr_d;
    logic [IDW-1:0]     cand;
    logic               win_vld;
    logic [WIDTH-1:0]   win_a;
    logic [WIDTH-1:0]   win_b;
    logic [NUM_REQ-1:0] grant_oh;
    int                 idx;

    // Scan from the highest offset down so the nearest set bit after rr_ptr wins.
    always_comb begin
        win_vld    = 1'b0;
        grant_id_d = '0;
        cand       = '0;
        idx        = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(rr_ptr_q) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = IDW'(idx);
            if (bus.req[cand]) begin
                win_vld    = 1'b1;
                grant_id_d = cand;
            end
        end
    end

    assign win_a    = bus.req_a[int'(grant_id_d)*WIDTH +: WIDTH];
    assign win_b    = bus.req_b[int'(grant_id_d)*WIDTH +: WIDTH];
    assign rr_ptr_d = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);
    assign grant_oh = NUM_REQ'(1) << grant_id_q;

    assign bus.ack        = ack_q;
    assign bus.result     = result_q;
    assign bus.result_id  = result_id_q;
    assign bus.add_enable = add_en_q;
    assign bus.add_a      = add_a_q;
    assign bus.add_b      = add_b_q;

`ifdef ADD_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);
    logic [TCW-1:0] tmo_cnt_q;
    logic           terr_q;
    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            result_id_q <= '0;
            ack_q       <= '0;
            result_q    <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_en_q    <= 1'b0;
`ifdef ADD_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            terr_q      <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
`ifdef ADD_ARB_TIMEOUT_EN
            terr_q <= 1'b0;
`endif
            case (state_q)
                // A done still high here belongs to an op abandoned by reset.
                IDLE: begin
                    if (win_vld && !bus.add_done) begin
                        grant_id_q <= grant_id_d;
                        add_a_q    <= win_a;
                        add_b_q    <= win_b;
                        add_en_q   <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    add_en_q <= 1'b0;
                    state_q  <= WAIT;
`ifdef ADD_ARB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                WAIT: begin
                    if (bus.add_done) begin
                        result_q    <= bus.add_sum;
                        result_id_q <= grant_id_q;
                        ack_q       <= grant_oh;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= RELEASE;
                    end
`ifdef ADD_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == TCW'(TIMEOUT - 1)) begin
                        result_q    <= '0;
                        result_id_q <= grant_id_q;
                        ack_q       <= grant_oh;
                        terr_q      <= 1'b1;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= RELEASE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TCW'(1);
                    end
`endif
                end
                RELEASE: begin
                    if (!bus.add_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_share_arbiter.sv
// Randomised self-checking bench for add_share_arbiter with a behavioural adder and
// a round-robin reference model; the timeout checks follow ADD_ARB_TIMEOUT_EN.
module tb_add_share_arbiter;
    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    add_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    add_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [N-1:0]   req_m   = '0;
    logic [N*W-1:0] req_a_m = '0;
    logic [N*W-1:0] req_b_m = '0;
    logic           done_m  = 1'b0;
    logic [W-1:0]   sum_m   = '0;
    logic           en_seen = 1'b0;
    bit             stuck   = 1'b0;
    bit             force_done = 1'b0;

    assign bus.req      = req_m;
    assign bus.req_a    = req_a_m;
    assign bus.req_b    = req_b_m;
    assign bus.add_done = done_m;
    assign bus.add_sum  = sum_m;

    int checks  = 0;
    int errors  = 0;
    int mdl_ptr = 0;

    typedef struct {
        int           glat;
        logic [W-1:0] ga;
        logic [W-1:0] gb;
        int           en_cyc;
        int           alat;
        logic [N-1:0] ack;
        logic [W-1:0] res;
        logic [1:0]   id;
        logic         terr;
        logic         terr_any;
        logic [N-1:0] ack_next;
    } obs_t;

    function automatic logic [W-1:0] ref_sat(input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return s[15:0];
    endfunction

    // Round-robin rule: first set request at or after the pointer, wrapping.
    function automatic int ref_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 4))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Adder: sees enable one edge after the pulse, raises done on the following edge.
    always @(posedge clk) begin
        if (stuck) begin
            en_seen <= 1'b0;
            done_m  <= 1'b0;
        end else begin
            en_seen <= bus.add_enable;
            done_m  <= en_seen | force_done;
            if (en_seen) sum_m <= ref_sat(bus.add_a, bus.add_b);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a_m[i*W +: W] = a;
        req_b_m[i*W +: W] = b;
    endtask

    // Observes one transaction; drops the acked request, optionally re-raising it later.
    task automatic run_txn(input bit scramble, input bit rearm, output obs_t o);
        o.glat = -1; o.alat = -1; o.ga = '0; o.gb = '0; o.en_cyc = 0;
        o.ack = '0; o.res = '0; o.id = '0; o.terr = 1'b0; o.terr_any = 1'b0; o.ack_next = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.add_enable === 1'b1) begin
                o.glat = c;
                break;
            end
        end
        if (o.glat < 0) return;
        o.ga = bus.add_a;
        o.gb = bus.add_b;
        o.en_cyc = 1;
        if (scramble) begin
            req_a_m = ~req_a_m;
            req_b_m = ~req_b_m;
        end
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.add_enable === 1'b1) o.en_cyc++;
            if (bus.timeout_err === 1'b1) o.terr_any = 1'b1;
            if (bus.ack !== '0) begin
                o.alat = c;
                break;
            end
        end
        if (o.alat < 0) return;
        o.ack  = bus.ack;
        o.res  = bus.result;
        o.id   = bus.result_id;
        o.terr = bus.timeout_err;
        req_m  = req_m & ~bus.ack;
        tick();
        o.ack_next = bus.ack;
        if (rearm) req_m = req_m | o.ack;
    endtask

    task automatic test_reset();
        logic seen;
        rst = 1'b1;
        req_m = '0;
        repeat (3) tick();
        checks++;
        if ({bus.ack, bus.result, bus.result_id, bus.timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack/result/id/terr=%h required 0",
                     {bus.ack, bus.result, bus.result_id, bus.timeout_err});
        end
        checks++;
        if ({bus.add_enable, bus.add_a, bus.add_b} !== '0) begin
            errors++;
            $display("FAIL reset_adder_port: en/a/b=%h required 0", {bus.add_enable, bus.add_a, bus.add_b});
        end
        rst = 1'b0;
        mdl_ptr = 0;
        seen = 1'b0;
        repeat (4) begin
            tick();
            if (bus.add_enable !== 1'b0 || bus.ack !== '0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: activity=%0b required 0", seen);
        end
    endtask

    task automatic test_single();
        obs_t o;
        int exp_id;
        logic [W-1:0] exp_res;
        logic [N-1:0] exp_ack;
        set_ops(0, 16'h0100, 16'h0200);
        req_m = 4'b0001;
        exp_id  = ref_pick(req_m, mdl_ptr);
        exp_res = ref_sat(req_a_m[exp_id*W +: W], req_b_m[exp_id*W +: W]);
        exp_ack = 4'(1) << exp_id;
        run_txn(1'b1, 1'b0, o);
        checks++;
        if (o.glat !== 1) begin errors++; $display("FAIL single_grant_lat: got %0d required 1", o.glat); end
        checks++;
        if ({o.ga, o.gb} !== 32'h0100_0200) begin
            errors++; $display("FAIL single_operands: got %h required 01000200", {o.ga, o.gb});
        end
        checks++;
        if (o.en_cyc !== 1) begin errors++; $display("FAIL single_enable_len: got %0d required 1", o.en_cyc); end
        checks++;
        if (o.alat !== 3) begin errors++; $display("FAIL single_ack_lat: got %0d required 3", o.alat); end
        checks++;
        if ({o.ack, o.id} !== {exp_ack, 2'(exp_id)}) begin
            errors++; $display("FAIL single_ack_id: got %b/%0d required %b/%0d", o.ack, o.id, exp_ack, exp_id);
        end
        checks++;
        if (o.res !== exp_res || o.res !== 16'h0300) begin
            errors++; $display("FAIL single_result: got %h required 0300", o.res);
        end
        checks++;
        if ({o.terr, o.ack_next} !== '0) begin
            errors++; $display("FAIL single_pulse: terr=%b ack_next=%b required 0/0000", o.terr, o.ack_next);
        end
        mdl_ptr = (exp_id + 1) % N;
    endtask

    task automatic test_saturation();
        int           rq[2] = '{1, 3};
        logic [W-1:0] av[2] = '{16'h7000, 16'h8000};
        logic [W-1:0] bv[2] = '{16'h2000, 16'hF000};
        logic [W-1:0] rv[2] = '{16'h7FFF, 16'h8000};
        obs_t o;
        int exp_id;
        for (int k = 0; k < 2; k++) begin
            set_ops(rq[k], av[k], bv[k]);
            req_m = '0;
            req_m[rq[k]] = 1'b1;
            exp_id = ref_pick(req_m, mdl_ptr);
            run_txn(1'b0, 1'b0, o);
            checks++;
            if (o.res !== rv[k]) begin
                errors++; $display("FAIL sat_result_%0d: got %h required %h", k, o.res, rv[k]);
            end
            checks++;
            if (o.id !== 2'(exp_id) || o.glat !== 1) begin
                errors++; $display("FAIL sat_grant_%0d: id=%0d lat=%0d required id=%0d lat=1", k, o.id, o.glat, exp_id);
            end
            mdl_ptr = (exp_id + 1) % N;
        end
    endtask

    task automatic test_round_robin();
        obs_t o;
        int exp_id;
        logic [W-1:0] exp_res;
        for (int i = 0; i < N; i++) set_ops(i, pick_val(), pick_val());
        req_m = '1;
        for (int k = 0; k < N; k++) begin
            exp_id  = ref_pick(req_m, mdl_ptr);
            exp_res = ref_sat(req_a_m[exp_id*W +: W], req_b_m[exp_id*W +: W]);
            run_txn(1'b0, 1'b0, o);
            checks++;
            if (o.id !== 2'(exp_id) || o.ack !== 4'(1) << exp_id) begin
                errors++; $display("FAIL rr_order_%0d: id=%0d ack=%b required id=%0d", k, o.id, o.ack, exp_id);
            end
            checks++;
            if (o.glat !== 1) begin errors++; $display("FAIL rr_spacing_%0d: got %0d required 1", k, o.glat); end
            checks++;
            if (o.res !== exp_res) begin errors++; $display("FAIL rr_result_%0d: got %h required %h", k, o.res, exp_res); end
            mdl_ptr = (exp_id + 1) % N;
        end
    endtask

    task automatic test_fairness();
        obs_t o;
        int exp_id;
        req_m = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            exp_id = ref_pick(req_m, mdl_ptr);
            run_txn(1'b0, 1'b1, o);
            checks++;
            if (o.id !== 2'(exp_id) || o.glat !== 1) begin
                errors++; $display("FAIL fair_%0d: id=%0d lat=%0d required id=%0d lat=1", k, o.id, o.glat, exp_id);
            end
            mdl_ptr = (exp_id + 1) % N;
        end
        req_m = '0;
    endtask

    task automatic test_random();
        obs_t o;
        int exp_id;
        logic [W-1:0] exp_res;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < N; i++) set_ops(i, pick_val(), pick_val());
            if (req_m == '0) req_m = 4'($urandom_range(1, 15));
            else req_m = req_m | (4'($urandom) & 4'($urandom));
            exp_id  = ref_pick(req_m, mdl_ptr);
            exp_res = ref_sat(req_a_m[exp_id*W +: W], req_b_m[exp_id*W +: W]);
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
            checks++;
            if (o.id !== 2'(exp_id) || o.ack !== 4'(1) << exp_id || o.glat !== 1) begin
                errors++;
                $display("FAIL rand_grant_%0d: id=%0d ack=%b lat=%0d required id=%0d lat=1", it, o.id, o.ack, o.glat, exp_id);
            end
            checks++;
            if (o.res !== exp_res) begin errors++; $display("FAIL rand_result_%0d: got %h required %h", it, o.res, exp_res); end
            mdl_ptr = (exp_id + 1) % N;
        end
        req_m = '0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int g;
        int exp_id;
        logic seen;
        set_ops(2, 16'h1234, 16'h0001);
        req_m = 4'b0100;
        g = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.add_enable === 1'b1) begin g = c; break; end
        end
        checks++;
        if (g < 0) begin errors++; $display("FAIL rmid_grant: no grant within 20 clocks, required grant"); end
        tick();
        force_done = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.ack, bus.result, bus.result_id, bus.add_enable, bus.add_a, bus.add_b} !== '0) begin
            errors++; $display("FAIL rmid_outputs: got %h required 0",
                               {bus.ack, bus.result, bus.result_id, bus.add_enable, bus.add_a, bus.add_b});
        end
        seen = 1'b0;
        repeat (2) begin tick(); if (bus.ack !== '0) seen = 1'b1; end
        rst = 1'b0;
        mdl_ptr = 0;
        repeat (6) begin
            tick();
            if (bus.add_enable !== 1'b0 || bus.ack !== '0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rmid_done_guard: activity=%0b required 0", seen); end
        force_done = 1'b0;
        exp_id = ref_pick(req_m, mdl_ptr);
        run_txn(1'b0, 1'b0, o);
        checks++;
        if (o.glat !== 2) begin errors++; $display("FAIL rmid_regrant_lat: got %0d required 2", o.glat); end
        checks++;
        if (o.id !== 2'(exp_id) || o.res !== 16'h1235) begin
            errors++; $display("FAIL rmid_result: id=%0d res=%h required id=%0d res=1235", o.id, o.res, exp_id);
        end
        mdl_ptr = (exp_id + 1) % N;
        req_m = '0;
    endtask

    task automatic test_stuck_adder();
        obs_t o;
        int exp_id;
        set_ops(0, 16'h4000, 16'h4000);
        req_m = 4'b0001;
        stuck = 1'b1;
        exp_id = ref_pick(req_m, mdl_ptr);
        run_txn(1'b0, 1'b0, o);
        checks++;
        if (o.glat !== 1) begin errors++; $display("FAIL stuck_grant: got %0d required 1", o.glat); end
`ifdef ADD_ARB_TIMEOUT_EN
        checks++;
        if (o.alat !== TMO + 1) begin errors++; $display("FAIL tmo_latency: got %0d required %0d", o.alat, TMO + 1); end
        checks++;
        if ({o.ack, o.id, o.res, o.terr} !== {4'(1) << exp_id, 2'(exp_id), 16'h0000, 1'b1}) begin
            errors++; $display("FAIL tmo_response: ack=%b id=%0d res=%h terr=%b required id=%0d res=0000 terr=1",
                               o.ack, o.id, o.res, o.terr, exp_id);
        end
        checks++;
        if (o.ack_next !== '0 || bus.timeout_err !== 1'b0) begin
            errors++; $display("FAIL tmo_pulse: ack_next=%b terr=%b required 0000/0", o.ack_next, bus.timeout_err);
        end
        mdl_ptr = (exp_id + 1) % N;
        stuck = 1'b0;
        req_m = 4'b0001;
`else
        checks++;
        if (o.alat !== -1 || o.terr_any !== 1'b0 || bus.timeout_err !== 1'b0) begin
            errors++; $display("FAIL stuck_wait: ack_lat=%0d terr=%b required no ack, terr 0", o.alat, o.terr_any);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_ptr = 0;
        stuck = 1'b0;
`endif
        exp_id = ref_pick(req_m, mdl_ptr);
        run_txn(1'b0, 1'b0, o);
        checks++;
        if (o.glat !== 1 || o.id !== 2'(exp_id) || o.res !== 16'h7FFF) begin
            errors++; $display("FAIL stuck_recover: lat=%0d id=%0d res=%h required lat=1 id=%0d res=7fff",
                               o.glat, o.id, o.res, exp_id);
        end
        mdl_ptr = (exp_id + 1) % N;
        req_m = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_round_robin();
        test_fairness();
        test_random();
        test_reset_mid();
        test_stuck_adder();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
